// File: rtl/span_pkg.sv
// Shared constants, register map and loader state type for the span_cme loader.
// Optional readback verification is enabled with SPAN_LOADER_READBACK_EN.
package span_pkg;

    localparam int DATA_W       = 16;
    localparam int OFFSET_W     = 6;
    localparam int NUM_REGS     = 34;
    localparam int CALC_LATENCY = 8;

    localparam logic [OFFSET_W-1:0] OFF_PRICE = 6'd0;
    localparam logic [OFFSET_W-1:0] OFF_LAST  = 6'd33;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        WAIT,
        OUT,
        DRAIN
    } loader_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/span_shadow_regs.sv
// Shadow copy of the words written to span_cme, used to check readback data.
// Single write port, registered read port; no reset on the storage.
module span_shadow_regs
    import span_pkg::*;
#(
    parameter int DEPTH = NUM_REGS,
    parameter int WIDTH = DATA_W,
    parameter int AW    = OFFSET_W
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write incoming word, return stored word one cycle after the address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/span_param_loader.sv
// Streams one contract record onto the span_cme register bus, waits for the
// scan calculation and returns priceScanRange. Readback: SPAN_LOADER_READBACK_EN.
module span_param_loader
    import span_pkg::*;
#(
    parameter int DATA_W       = span_pkg::DATA_W,
    parameter int OFFSET_W     = span_pkg::OFFSET_W,
    parameter int NUM_REGS     = span_pkg::NUM_REGS,
    parameter int CALC_LATENCY = span_pkg::CALC_LATENCY
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic [DATA_W-1:0]   writeData,
    output logic [OFFSET_W-1:0] offset,
    output logic                write,
    output logic                chipselect,
    output logic                read,
    input  logic [DATA_W-1:0]   readData,
    input  logic [DATA_W-1:0]   priceScanRange,
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_data,
    input  logic                res_ready,
    output logic                err_len,
    output logic                err_readback,
    output logic                busy
);

    localparam int CNT_MAX = max_int(NUM_REGS, CALC_LATENCY);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(CALC_LATENCY - 1);

    loader_state_t       r_state, w_state_n;
    logic [CNT_W-1:0]    r_cnt, w_cnt_n;
    logic                r_write, w_write_n;
    logic                r_read, w_read_n;
    logic                r_cs, w_cs_n;
    logic [OFFSET_W-1:0] r_offset, w_offset_n;
    logic [DATA_W-1:0]   r_wdata, w_wdata_n;
    logic                r_res_valid, w_res_valid_n;
    logic [DATA_W-1:0]   r_res_data, w_res_data_n;
    logic                r_err_len, w_err_len_n;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_load_word;
    logic [CNT_W-1:0]    w_widx;
    logic [OFFSET_W-1:0] w_waddr;

    assign w_in_ready  = (r_state == IDLE) || (r_state == LOAD)
                      || (r_state == DRAIN);
    assign w_accept    = in_valid && w_in_ready;
    assign w_load_word = w_accept
                      && ((r_state == IDLE) || (r_state == LOAD));
    // A word taken in IDLE always starts a fresh record at offset 0.
    assign w_widx      = (r_state == LOAD) ? r_cnt : '0;
    assign w_waddr     = OFFSET_W'(w_widx);

    // Next state, word/latency counter and registered bus/result values.
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_write_n     = 1'b0;
        w_read_n      = 1'b0;
        w_cs_n        = 1'b0;
        w_offset_n    = r_offset;
        w_wdata_n     = r_wdata;
        w_res_valid_n = r_res_valid;
        w_res_data_n  = r_res_data;
        w_err_len_n   = 1'b0;

        if (w_load_word) begin
            w_write_n  = 1'b1;
            w_cs_n     = 1'b1;
            w_offset_n = w_waddr;
            w_wdata_n  = in_data;
        end

        unique case (r_state)
            IDLE, LOAD: begin
                if (w_accept) begin
                    if (w_widx == LAST_WORD) begin
                        w_cnt_n = '0;
                        if (in_last) begin
`ifdef SPAN_LOADER_READBACK_EN
                            w_state_n = VERIFY;
`else
                            w_state_n = WAIT;
`endif
                        end else begin
                            w_err_len_n = 1'b1;
                            w_state_n   = DRAIN;
                        end
                    end else if (in_last) begin
                        w_err_len_n = 1'b1;
                        w_state_n   = IDLE;
                    end else begin
                        w_state_n = LOAD;
                        w_cnt_n   = w_widx + 1'b1;
                    end
                end
            end
            VERIFY: begin
`ifdef SPAN_LOADER_READBACK_EN
                w_read_n   = 1'b1;
                w_cs_n     = 1'b1;
                w_offset_n = OFFSET_W'(r_cnt);
                if (r_cnt == LAST_WORD) begin
                    w_state_n = WAIT;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
`else
                w_state_n = IDLE;
`endif
            end
            WAIT: begin
                if (r_cnt == LAST_WAIT) begin
                    w_res_valid_n = 1'b1;
                    w_res_data_n  = priceScanRange;
                    w_state_n     = OUT;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            OUT: begin
                if (res_ready) begin
                    w_res_valid_n = 1'b0;
                    w_state_n     = IDLE;
                end
            end
            DRAIN: begin
                if (w_accept && in_last) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial record.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_cs        <= 1'b0;
            r_offset    <= '0;
            r_wdata     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_err_len   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_write     <= w_write_n;
            r_read      <= w_read_n;
            r_cs        <= w_cs_n;
            r_offset    <= w_offset_n;
            r_wdata     <= w_wdata_n;
            r_res_valid <= w_res_valid_n;
            r_res_data  <= w_res_data_n;
            r_err_len   <= w_err_len_n;
        end
    end

`ifdef SPAN_LOADER_READBACK_EN
    logic [DATA_W-1:0] w_shadow_q;
    logic              r_cmp_vld;
    logic              r_err_rb;

    span_shadow_regs #(
        .DEPTH (NUM_REGS),
        .WIDTH (DATA_W),
        .AW    (OFFSET_W)
    ) u_shadow (
        .clk     (clk),
        .i_we    (w_load_word),
        .i_waddr (w_waddr),
        .i_wdata (in_data),
        .i_raddr (r_offset),
        .o_rdata (w_shadow_q)
    );

    // Compare span_cme read data with the shadow one cycle after each read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp_vld <= 1'b0;
            r_err_rb  <= 1'b0;
        end else begin
            r_cmp_vld <= r_read;
            r_err_rb  <= r_cmp_vld && (readData != w_shadow_q);
        end
    end

    assign err_readback = r_err_rb;
`else
    logic w_unused_rd;
    assign w_unused_rd  = ^readData;
    assign err_readback = 1'b0;
`endif

    assign in_ready   = w_in_ready;
    assign writeData  = r_wdata;
    assign offset     = r_offset;
    assign write      = r_write;
    assign chipselect = r_cs;
    assign read       = r_read;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign err_len    = r_err_len;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_span_param_loader.sv
// Directed bench for span_param_loader with a small span_cme model
// (priceScanRange = reg9 + reg10, optional corruption of offset 5 on read).
module tb_span_param_loader;

    localparam int DW = 16;
    localparam int OW = 6;
    localparam int NR = 34;
    localparam int CL = 8;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] writeData;
    logic [OW-1:0] offset;
    logic          write;
    logic          chipselect;
    logic          read;
    logic [DW-1:0] readData;
    logic [DW-1:0] priceScanRange;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          err_len;
    logic          err_readback;
    logic          busy;

    span_param_loader dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .writeData      (writeData),
        .offset         (offset),
        .write          (write),
        .chipselect     (chipselect),
        .read           (read),
        .readData       (readData),
        .priceScanRange (priceScanRange),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .err_len        (err_len),
        .err_readback   (err_readback),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_fail;

    int rec_init [NR] = '{
        96, 15, -5, 10, -15, 5, -15, 0, 0, 1750,
        2500, 2, 1, 55, 60, 62, 64, 66, 68, 70,
        72, 74, 76, 78, 80, 82, 84, 86, 88, 90,
        92, 100, 110, 120
    };
    logic [DW-1:0] words [40];

    // span_cme model
    logic [DW-1:0] cme [NR];
    logic          corrupt;

    always @(posedge clk) begin
        if (chipselect && write) cme[offset] <= writeData;
        if (chipselect && read) begin
            readData <= cme[offset]
                      ^ ((corrupt && offset == 6'd5) ? 16'h0001 : 16'h0000);
        end
        priceScanRange <= cme[9] + cme[10];
    end

    // bus/result monitor
    int            cyc;
    int            wr_cnt [NR];
    logic [DW-1:0] wd_seen [NR];
    int            wr_total, rd_total, bad_off;
    int            hs_cnt, el_cnt, erb_cnt;
    int            last_strobe_cyc, hs_cyc, first_rv_cyc, idle_acc_cyc;
    logic [DW-1:0] last_res;

    always @(negedge clk) begin
        cyc++;
        if (chipselect && write) begin
            wr_total++;
            if (offset < OW'(NR)) begin
                wr_cnt[offset]++;
                wd_seen[offset] = writeData;
            end else begin
                bad_off++;
            end
        end
        if (chipselect && read) rd_total++;
        if (chipselect && (write || read) && offset == 6'd33)
            last_strobe_cyc = cyc;
        if (res_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (res_valid && res_ready) begin
            hs_cnt++;
            hs_cyc   = cyc;
            last_res = res_data;
        end
        if (err_len) el_cnt++;
        if (err_readback) erb_cnt++;
        if (in_valid && in_ready && !busy) idle_acc_cyc = cyc;
    end

    task automatic clear_mon();
        for (int k = 0; k < NR; k++) begin
            wr_cnt[k]  = 0;
            wd_seen[k] = '0;
        end
        wr_total        = 0;
        rd_total        = 0;
        bad_off         = 0;
        hs_cnt          = 0;
        el_cnt          = 0;
        erb_cnt         = 0;
        last_strobe_cyc = -1;
        hs_cyc          = -1;
        first_rv_cyc    = -1;
        idle_acc_cyc    = -1;
        last_res        = '0;
    endtask

    task automatic fill_default();
        for (int k = 0; k < 40; k++) begin
            if (k < NR) words[k] = 16'(rec_init[k]);
            else        words[k] = 16'(k);
        end
    endtask

    // Offer words 0..n-1; returns at posedge+1 after the last acceptance.
    task automatic send(input int n, input int last_idx, output bit ok);
        bit acc;
        int budget;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = words[k];
            in_last  = (k == last_idx);
            acc      = 1'b0;
            budget   = 0;
            while (!acc && budget < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) begin
                ok = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res(input int max, output bit got);
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_ok(input string name, input bit ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got timeout, required completion", name);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        corrupt   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({write, chipselect, read, res_valid, err_len, err_readback, busy}
            !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000000",
                {write, chipselect, read, res_valid, err_len,
                 err_readback, busy});
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        n_chk++;
        if ({offset, writeData, res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: off %h wd %h rd %h required 0",
                offset, writeData, res_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_full_record();
        bit ok, got;
        fill_default();
        res_ready = 1'b1;
        clear_mon();
        send(NR, NR - 1, ok);
        chk_ok("full_send", ok);
        wait_res(120, got);
        chk_ok("full_result", got);
        repeat (4) @(posedge clk);
        #1;
        n_chk++;
        if (hs_cnt !== 1) begin
            n_fail++;
            $display("FAIL full_res_count: got %0d required 1", hs_cnt);
        end
        n_chk++;
        if (last_res !== 16'd4250) begin
            n_fail++;
            $display("FAIL full_res_data: got %h required %h",
                last_res, 16'd4250);
        end
        n_chk++;
        if (first_rv_cyc - last_strobe_cyc !== CL) begin
            n_fail++;
            $display("FAIL full_latency: got %0d required %0d",
                first_rv_cyc - last_strobe_cyc, CL);
        end
        n_chk++;
        if (wd_seen[2] !== 16'hFFFB) begin
            n_fail++;
            $display("FAIL full_wd2: got %h required FFFB", wd_seen[2]);
        end
        for (int k = 0; k < NR; k++) begin
            n_chk++;
            if (wr_cnt[k] !== 1 || wd_seen[k] !== words[k]) begin
                n_fail++;
                $display("FAIL full_word%0d: got n=%0d d=%h required n=1 d=%h",
                    k, wr_cnt[k], wd_seen[k], words[k]);
            end
        end
        n_chk++;
        if (el_cnt !== 0 || erb_cnt !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_idle: got el=%0d erb=%0d busy=%b required 0 0 0",
                el_cnt, erb_cnt, busy);
        end
    endtask

    task automatic test_short_record();
        bit ok;
        fill_default();
        res_ready = 1'b1;
        clear_mon();
        send(11, 10, ok);
        chk_ok("short_send", ok);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL short_busy: got %b required 0", busy);
        end
        repeat (20) @(posedge clk);
        #1;
        n_chk++;
        if (el_cnt !== 1 || hs_cnt !== 0 || wr_total !== 11) begin
            n_fail++;
            $display("FAIL short_counts: got el=%0d res=%0d wr=%0d required 1 0 11",
                el_cnt, hs_cnt, wr_total);
        end
    endtask

    task automatic test_long_record();
        bit ok;
        fill_default();
        res_ready = 1'b1;
        clear_mon();
        send(40, 39, ok);
        chk_ok("long_send", ok);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL long_busy: got %b required 0", busy);
        end
        repeat (20) @(posedge clk);
        #1;
        n_chk++;
        if (el_cnt !== 1 || hs_cnt !== 0) begin
            n_fail++;
            $display("FAIL long_counts: got el=%0d res=%0d required 1 0",
                el_cnt, hs_cnt);
        end
        n_chk++;
        if (wr_total !== NR || bad_off !== 0 || wr_cnt[33] !== 1) begin
            n_fail++;
            $display("FAIL long_writes: got wr=%0d bad=%0d w33=%0d required 34 0 1",
                wr_total, bad_off, wr_cnt[33]);
        end
    endtask

    task automatic test_backpressure();
        bit ok, got;
        fill_default();
        words[9]  = 16'hFED4;
        words[10] = 16'd77;
        res_ready = 1'b0;
        clear_mon();
        send(NR, NR - 1, ok);
        chk_ok("bp_send", ok);
        wait_res(120, got);
        chk_ok("bp_result", got);
        for (int i = 0; i < 20; i++) begin
            n_chk++;
            if ({res_valid, in_ready, res_data} !== {1'b1, 1'b0, 16'hFF21}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b d=%h required 1 0 FF21",
                    i, res_valid, in_ready, res_data);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({busy, res_valid, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL bp_release: got busy=%b v=%b rdy=%b required 0 0 1",
                busy, res_valid, in_ready);
        end
        n_chk++;
        if (hs_cnt !== 1 || last_res !== 16'hFF21) begin
            n_fail++;
            $display("FAIL bp_handshake: got n=%0d d=%h required 1 FF21",
                hs_cnt, last_res);
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok, got;
        fill_default();
        res_ready = 1'b1;
        clear_mon();
        send(13, -1, ok);
        chk_ok("rst_send", ok);
        n_chk++;
        if (write !== 1'b1 || offset !== 6'd12) begin
            n_fail++;
            $display("FAIL rst_pre: got wr=%b off=%0d required 1 12",
                write, offset);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({write, chipselect, read, res_valid, err_len, err_readback, busy,
             in_ready} !== 8'b0000_0001
            || {offset, writeData, res_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got %b off=%h wd=%h required 00000001 0 0",
                {write, chipselect, read, res_valid, err_len, err_readback,
                 busy, in_ready}, offset, writeData);
        end
        reset     = 1'b0;
        words[9]  = 16'd100;
        words[10] = 16'd23;
        clear_mon();
        send(NR, NR - 1, ok);
        chk_ok("rst_resend", ok);
        wait_res(120, got);
        chk_ok("rst_result", got);
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (hs_cnt !== 1 || last_res !== 16'd123 || el_cnt !== 0) begin
            n_fail++;
            $display("FAIL rst_after: got n=%0d d=%h el=%0d required 1 007B 0",
                hs_cnt, last_res, el_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, got;
        int gap;
        fill_default();
        res_ready = 1'b1;
        clear_mon();
        send(NR, NR - 1, ok);
        chk_ok("b2b_send1", ok);
        words[9]  = 16'd5;
        words[10] = 16'd6;
        send(NR, NR - 1, ok);
        chk_ok("b2b_send2", ok);
        gap = idle_acc_cyc - hs_cyc;
        n_chk++;
        if (gap !== 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d required 1", gap);
        end
        wait_res(120, got);
        chk_ok("b2b_result", got);
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (hs_cnt !== 2 || last_res !== 16'd11) begin
            n_fail++;
            $display("FAIL b2b_res: got n=%0d d=%h required 2 000B",
                hs_cnt, last_res);
        end
    endtask

`ifdef SPAN_LOADER_READBACK_EN
    task automatic test_readback();
        bit ok, got;
        fill_default();
        res_ready = 1'b1;
        corrupt   = 1'b1;
        clear_mon();
        send(NR, NR - 1, ok);
        chk_ok("rb_send", ok);
        wait_res(160, got);
        chk_ok("rb_result", got);
        repeat (5) @(posedge clk);
        #1;
        n_chk++;
        if (erb_cnt !== 1 || rd_total !== NR) begin
            n_fail++;
            $display("FAIL rb_err: got erb=%0d rd=%0d required 1 34",
                erb_cnt, rd_total);
        end
        n_chk++;
        if (hs_cnt !== 1 || last_res !== 16'd4250) begin
            n_fail++;
            $display("FAIL rb_res: got n=%0d d=%h required 1 %h",
                hs_cnt, last_res, 16'd4250);
        end
        corrupt = 1'b0;
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        for (int k = 0; k < NR; k++) cme[k] = '0;
        readData       = '0;
        priceScanRange = '0;
        clear_mon();
        test_reset();
        test_full_record();
        test_short_record();
        test_long_record();
        test_backpressure();
        test_reset_mid_load();
        test_back_to_back();
`ifdef SPAN_LOADER_READBACK_EN
        test_readback();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end

endmodule
